// File: rtl/cache_write_back.sv
// Direct-mapped, write-back, write-allocate data cache: 128 lines of 4 x 32-bit words.
// Hits and write-back exposure are combinational; all line updates land on the rising edge.
module cache_write_back (
  input  logic         clk,
  input  logic         reset,
  input  logic         read,
  input  logic         write,
  input  logic [31:0]  memoryaddress,
  input  logic [31:0]  writedata,
  input  logic [127:0] mainmemorydata,
  input  logic         cachewrite_enable,
  input  logic         stall_en,
  output logic         hit,
  output logic [31:0]  readdata,
  output logic [31:0]  writebackaddress,
  output logic [127:0] writebackdata,
  output logic         writeback_enable
);

  logic [127:0] r_valid;
  logic [127:0] r_dirty;
  logic [20:0]  r_tag  [128];
  logic [127:0] r_data [128];

  logic [20:0]  w_tag;
  logic [6:0]   w_idx;
  logic [1:0]   w_word;
  logic [6:0]   w_bit;
  logic         w_req;
  logic         w_hit;
  logic         w_miss;
  logic         w_wb;
  logic         w_line_we;
  logic [127:0] w_line;
  logic [127:0] w_new_line;

  assign w_tag  = memoryaddress[31:11];
  assign w_idx  = memoryaddress[10:4];
  assign w_word = memoryaddress[3:2];
  assign w_bit  = {w_word, 5'd0};
  assign w_req  = read | write;
  assign w_line = r_data[w_idx];

  assign w_hit  = w_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_miss = w_req & ~w_hit;
  assign w_wb   = w_miss & r_valid[w_idx] & r_dirty[w_idx];

  // A line is written on a write hit or on any refilled miss; a stall suppresses both.
  assign w_line_we = ~stall_en & ((write & w_hit) | (w_miss & cachewrite_enable));

  // Refills start from the memory block; write hits start from the current line.
  always_comb begin
    w_new_line = w_hit ? w_line : mainmemorydata;
    if (write) begin
      w_new_line[w_bit +: 32] = writedata;
    end
  end

  assign hit              = w_hit;
  assign readdata         = (read & ~write & w_hit) ? w_line[w_bit +: 32] : 32'd0;
  assign writeback_enable = w_wb;
  assign writebackaddress = w_wb ? {r_tag[w_idx], w_idx, 4'b0000} : 32'd0;
  assign writebackdata    = w_wb ? w_line : 128'd0;

  // Control state: only valid/dirty are reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_line_we) begin
      r_valid[w_idx] <= 1'b1;
      r_dirty[w_idx] <= write;
    end
  end

  // Data and tag storage carry no reset; a cleared valid bit masks stale contents.
  always_ff @(posedge clk) begin
    if (w_line_we) begin
      r_data[w_idx] <= w_new_line;
      r_tag[w_idx]  <= w_tag;
    end
  end

endmodule

// File: tb/tb_cache_write_back.sv
// Self-checking bench for cache_write_back: directed requests with expected
// outputs queued at drive time and compared when the combinational outputs settle.
module tb_cache_write_back;

  logic         clk = 1'b0;
  logic         reset;
  logic         read;
  logic         write;
  logic [31:0]  memoryaddress;
  logic [31:0]  writedata;
  logic [127:0] mainmemorydata;
  logic         cachewrite_enable;
  logic         stall_en;
  logic         hit;
  logic [31:0]  readdata;
  logic [31:0]  writebackaddress;
  logic [127:0] writebackdata;
  logic         writeback_enable;

  cache_write_back dut (
    .clk               (clk),
    .reset             (reset),
    .read              (read),
    .write             (write),
    .memoryaddress     (memoryaddress),
    .writedata         (writedata),
    .mainmemorydata    (mainmemorydata),
    .cachewrite_enable (cachewrite_enable),
    .stall_en          (stall_en),
    .hit               (hit),
    .readdata          (readdata),
    .writebackaddress  (writebackaddress),
    .writebackdata     (writebackdata),
    .writeback_enable  (writeback_enable)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic         hit;
    logic [31:0]  rdata;
    logic         wbe;
    logic [31:0]  wba;
    logic [127:0] wbd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Drive one request on the falling edge, queue its expectation, compare 1ns later.
  task automatic apply(input string tag, input logic rst, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [127:0] mm, input logic ce, input logic st,
                       input logic e_hit, input logic [31:0] e_rd, input logic e_wbe,
                       input logic [31:0] e_wba, input logic [127:0] e_wbd);
    exp_t e;
    @(negedge clk);
    reset = rst; read = rd; write = wr; memoryaddress = addr; writedata = wd;
    mainmemorydata = mm; cachewrite_enable = ce; stall_en = st;
    e.tag = tag; e.hit = e_hit; e.rdata = e_rd; e.wbe = e_wbe; e.wba = e_wba; e.wbd = e_wbd;
    exp_q.push_back(e);
    #1;
    e = exp_q.pop_front();
    check_val({e.tag, ".hit"},  {127'd0, hit},              {127'd0, e.hit});
    check_val({e.tag, ".rd"},   {96'd0, readdata},          {96'd0, e.rdata});
    check_val({e.tag, ".wbe"},  {127'd0, writeback_enable}, {127'd0, e.wbe});
    check_val({e.tag, ".wba"},  {96'd0, writebackaddress},  {96'd0, e.wba});
    check_val({e.tag, ".wbd"},  writebackdata,              e.wbd);
  endtask

  localparam logic [127:0] PAT = {32'h0000000D, 32'h0000000C, 32'h0000000B, 32'h0000000A};

  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0; memoryaddress = '0; writedata = '0;
    mainmemorydata = '0; cachewrite_enable = 1'b0; stall_en = 1'b0;
    repeat (2) @(negedge clk);

    //             tag        rst rd wr addr          wd            mm       ce st  hit rd            wbe wba           wbd
    apply("rst_rd",   0, 1, 0, 32'h0,   32'h0,        128'h0,   0, 0,   0, 32'h0,        0, 32'h0,   128'h0);
    apply("wmiss0",   0, 0, 1, 32'h0,   32'h4,        128'h0,   1, 0,   0, 32'h0,        0, 32'h0,   128'h0);
    apply("rd0",      0, 1, 0, 32'h0,   32'h0,        128'h0,   0, 0,   1, 32'h4,        0, 32'h0,   128'h0);
    apply("rd4",      0, 1, 0, 32'h4,   32'h0,        128'h0,   0, 0,   1, 32'h0,        0, 32'h0,   128'h0);
    apply("wvict",    0, 0, 1, 32'h800, 32'h8,        128'h8,   1, 0,   0, 32'h0,        1, 32'h0,   128'h4);
    apply("rd800",    0, 1, 0, 32'h800, 32'h0,        128'h0,   0, 0,   1, 32'h8,        0, 32'h0,   128'h0);
    apply("rd0miss",  0, 1, 0, 32'h0,   32'h0,        128'h0,   0, 0,   0, 32'h0,        1, 32'h800, 128'h8);
    apply("wstall",   0, 0, 1, 32'h800, 32'h11111111, 128'h0,   0, 1,   1, 32'h0,        0, 32'h0,   128'h0);
    apply("rdstall",  0, 1, 0, 32'h800, 32'h0,        128'h0,   0, 0,   1, 32'h8,        0, 32'h0,   128'h0);
    apply("w400",     0, 0, 1, 32'h400, 32'h16,       128'h0,   1, 0,   0, 32'h0,        0, 32'h0,   128'h0);
    apply("rd400",    0, 1, 0, 32'h400, 32'h0,        128'h0,   0, 0,   1, 32'h16,       0, 32'h0,   128'h0);
    apply("w408",     0, 0, 1, 32'h408, 32'hAB,       128'h0,   0, 0,   1, 32'h0,        0, 32'h0,   128'h0);
    apply("rd408",    0, 1, 0, 32'h408, 32'h0,        128'h0,   0, 0,   1, 32'hAB,       0, 32'h0,   128'h0);
    apply("rd400b",   0, 1, 0, 32'h400, 32'h0,        128'h0,   0, 0,   1, 32'h16,       0, 32'h0,   128'h0);
    apply("rw408",    0, 1, 1, 32'h408, 32'hCD,       128'h0,   0, 0,   1, 32'h0,        0, 32'h0,   128'h0);
    apply("rd408b",   0, 1, 0, 32'h408, 32'h0,        128'h0,   0, 0,   1, 32'hCD,       0, 32'h0,   128'h0);
    apply("vict64",   0, 1, 0, 32'hC00, 32'h0,        128'h0,   0, 0,   0, 32'h0,        1, 32'h400,
          {32'h0, 32'hCD, 32'h0, 32'h16});
    for (int i = 0; i < 3; i++)
      apply("hold",   0, 1, 0, 32'h0,   32'h0,        PAT,      0, 0,   0, 32'h0,        1, 32'h800, 128'h8);
    apply("fillstl",  0, 1, 0, 32'h0,   32'h0,        PAT,      1, 1,   0, 32'h0,        1, 32'h800, 128'h8);
    apply("dropped",  0, 1, 0, 32'h0,   32'h0,        PAT,      0, 0,   0, 32'h0,        1, 32'h800, 128'h8);
    apply("rfill",    0, 1, 0, 32'h0,   32'h0,        PAT,      1, 0,   0, 32'h0,        1, 32'h800, 128'h8);
    apply("rdC",      0, 1, 0, 32'hC,   32'h0,        128'h0,   0, 0,   1, 32'hD,        0, 32'h0,   128'h0);
    apply("rd8",      0, 1, 0, 32'h8,   32'h0,        128'h0,   0, 0,   1, 32'hC,        0, 32'h0,   128'h0);
    apply("clean",    0, 1, 0, 32'h800, 32'h0,        128'h0,   0, 0,   0, 32'h0,        0, 32'h0,   128'h0);
    apply("idle",     0, 0, 0, 32'h0,   32'h0,        128'h0,   0, 0,   0, 32'h0,        0, 32'h0,   128'h0);
    apply("rstw",     1, 0, 1, 32'h400, 32'h99,       128'h0,   1, 0,   1, 32'h0,        0, 32'h0,   128'h0);
    apply("post400",  0, 1, 0, 32'h400, 32'h0,        128'h0,   0, 0,   0, 32'h0,        0, 32'h0,   128'h0);
    apply("postC",    0, 1, 0, 32'hC,   32'h0,        128'h0,   0, 0,   0, 32'h0,        0, 32'h0,   128'h0);
    apply("post800",  0, 1, 0, 32'h800, 32'h0,        128'h0,   0, 0,   0, 32'h0,        0, 32'h0,   128'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
